// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the 4-client bus arbiter.
// Imported by the selector and the grant controller.
package bus_arb_pkg;

    localparam int NUM_CLIENTS = 4;

    typedef logic [1:0] client_id_t;
    typedef logic [1:0] prio_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_e;

    localparam prio_t PRIO_HIGHEST = 2'b00;

    function automatic logic [NUM_CLIENTS-1:0] onehot(input client_id_t id);
        logic [NUM_CLIENTS-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_ctrl_prio_select.sv
// Combinational winner pick: lowest priority value among unmasked
// requesters, lowest client index on ties.
module prio_select
    import bus_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [NUM_CLIENTS-1:0] mask_i,
    input  prio_t                  prio_i [NUM_CLIENTS],
    output logic                   valid_o,
    output client_id_t             win_id_o
);

    logic [NUM_CLIENTS-1:0] cand;
    logic                   found;
    prio_t                  best;
    client_id_t             win;

    assign cand = req_i & ~mask_i;

    // Strict compare keeps the earlier (lower-index) client on a tie.
    always_comb begin
        found = 1'b0;
        best  = ~PRIO_HIGHEST;
        win   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (cand[i] && (!found || prio_i[i] < best)) begin
                found = 1'b1;
                best  = prio_i[i];
                win   = client_id_t'(i);
            end
        end
    end

    assign valid_o  = found;
    assign win_id_o = win;

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Grant controller for the shared bus: registered one-hot grant,
// hold timeout and one-cycle turnaround with last-owner masking.
module bus_arbiter_ctrl
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CLIENTS-1:0] req,
    input  prio_t                  client_1_priority,
    input  prio_t                  client_2_priority,
    input  prio_t                  client_3_priority,
    input  prio_t                  client_4_priority,
    output logic [NUM_CLIENTS-1:0] gnt,
    output client_id_t             gnt_id,
    output logic                   bus_busy,
    output logic                   timeout,
    output client_id_t             timeout_id
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_CLIENTS-1:0] gnt_q;
    client_id_t             gnt_id_q;
    client_id_t             last_id_q;
    client_id_t             timeout_id_q;
    logic                   busy_q;
    logic                   timeout_q;

    prio_t                  prio [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] last_oh;
    logic [NUM_CLIENTS-1:0] mask_d;
    logic                   sel_valid;
    client_id_t             sel_id;
    logic                   owner_req;
    logic                   hold_done;

    assign prio[0] = client_1_priority;
    assign prio[1] = client_2_priority;
    assign prio[2] = client_3_priority;
    assign prio[3] = client_4_priority;

    // The previous owner yields only if someone else is waiting.
    assign last_oh = onehot(last_id_q);
    assign mask_d  = (state_q == GAP && |(req & ~last_oh)) ? last_oh : '0;

    assign owner_req = req[gnt_id_q];
    assign hold_done = (cnt_q == CNT_LAST);

    prio_select u_sel (
        .req_i    (req),
        .mask_i   (mask_d),
        .prio_i   (prio),
        .valid_o  (sel_valid),
        .win_id_o (sel_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            last_id_q    <= '0;
            timeout_id_q <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE, GAP: begin
                    if (sel_valid) begin
                        state_q  <= GRANT;
                        gnt_q    <= onehot(sel_id);
                        gnt_id_q <= sel_id;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req || hold_done) begin
                        state_q   <= GAP;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        last_id_q <= gnt_id_q;
                        // A release on the final cycle is not a timeout.
                        if (owner_req) begin
                            timeout_q    <= 1'b1;
                            timeout_id_q <= gnt_id_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign gnt_id     = gnt_id_q;
    assign bus_busy   = busy_q;
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed vector bench for bus_arbiter_ctrl with MAX_HOLD=4.
// Vectors give inputs for one cycle and the outputs after its edge.
module tb_bus_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [1:0] p1, p2, p3, p4;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       bus_busy;
    logic       timeout;
    logic [1:0] timeout_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] prio;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
        logic [1:0] toid;
    } vec_t;

    vec_t vq[$];

    bus_arbiter_ctrl #(.MAX_HOLD(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .client_1_priority (p1),
        .client_2_priority (p2),
        .client_3_priority (p3),
        .client_4_priority (p4),
        .gnt               (gnt),
        .gnt_id            (gnt_id),
        .bus_busy          (bus_busy),
        .timeout           (timeout),
        .timeout_id        (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [3:0] r, input logic [7:0] p,
                       input logic [3:0] g, input logic [1:0] id,
                       input logic b, input logic t, input logic [1:0] tid);
        vec_t v;
        v.req = r; v.prio = p; v.gnt = g; v.id = id;
        v.busy = b; v.to = t; v.toid = tid;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] g,
                         input logic [1:0] id, input logic b,
                         input logic t, input logic [1:0] tid);
        n_tests++;
        if (gnt !== g || gnt_id !== id || bus_busy !== b ||
            timeout !== t || timeout_id !== tid) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b toid=%0d, want gnt=%b id=%0d busy=%b to=%b toid=%0d",
                     name, gnt, gnt_id, bus_busy, timeout, timeout_id,
                     g, id, b, t, tid);
        end
    endtask

    initial begin
        // prio packs {c4,c3,c2,c1}
        // simple grant and release
        add(4'b0001, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0001, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0001, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0000, 8'h00, 4'b0000, 2'd0, 0, 0, 2'd0);
        add(4'b0000, 8'h00, 4'b0000, 2'd0, 0, 0, 2'd0);
        add(4'b0000, 8'h00, 4'b0000, 2'd0, 0, 0, 2'd0);
        // priority pick: c1=11 c2=10 c3=00 c4=01
        add(4'b1111, 8'h4B, 4'b0100, 2'd2, 1, 0, 2'd0);
        add(4'b1011, 8'h4B, 4'b0000, 2'd2, 0, 0, 2'd0);
        add(4'b1011, 8'h4B, 4'b1000, 2'd3, 1, 0, 2'd0);
        add(4'b0000, 8'h4B, 4'b0000, 2'd3, 0, 0, 2'd0);
        add(4'b0000, 8'h4B, 4'b0000, 2'd3, 0, 0, 2'd0);
        // tie-break: c2=c4=01
        add(4'b1010, 8'h77, 4'b0010, 2'd1, 1, 0, 2'd0);
        add(4'b0000, 8'h77, 4'b0000, 2'd1, 0, 0, 2'd0);
        add(4'b0000, 8'h77, 4'b0000, 2'd1, 0, 0, 2'd0);
        // timeout with client 2 joining
        add(4'b0001, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0011, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0011, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0011, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0011, 8'h00, 4'b0000, 2'd0, 0, 1, 2'd0);
        add(4'b0011, 8'h00, 4'b0010, 2'd1, 1, 0, 2'd0);
        add(4'b0001, 8'h00, 4'b0000, 2'd1, 0, 0, 2'd0);
        add(4'b0001, 8'h00, 4'b0001, 2'd0, 1, 0, 2'd0);
        add(4'b0000, 8'h00, 4'b0000, 2'd0, 0, 0, 2'd0);
        add(4'b0000, 8'h00, 4'b0000, 2'd0, 0, 0, 2'd0);
        // release on the last hold cycle beats the timeout
        add(4'b0010, 8'h00, 4'b0010, 2'd1, 1, 0, 2'd0);
        add(4'b0010, 8'h00, 4'b0010, 2'd1, 1, 0, 2'd0);
        add(4'b0010, 8'h00, 4'b0010, 2'd1, 1, 0, 2'd0);
        add(4'b0010, 8'h00, 4'b0010, 2'd1, 1, 0, 2'd0);
        add(4'b0000, 8'h00, 4'b0000, 2'd1, 0, 0, 2'd0);
        add(4'b0000, 8'h00, 4'b0000, 2'd1, 0, 0, 2'd0);
        // sole requester: 4 on, 1 off, repeat
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++)
                add(4'b0100, 8'h00, 4'b0100, 2'd2, 1, 0,
                    (k == 0) ? 2'd0 : 2'd2);
            add(4'b0100, 8'h00, 4'b0000, 2'd2, 0, 1, 2'd2);
        end
        add(4'b0100, 8'h00, 4'b0100, 2'd2, 1, 0, 2'd2);

        reset = 1'b1;
        req   = '0;
        {p4, p3, p2, p1} = 8'h00;
        #1;
        check("reset_async", 4'b0000, 2'd0, 0, 0, 2'd0);
        @(posedge clk); #1;
        check("reset_state", 4'b0000, 2'd0, 0, 0, 2'd0);
        reset = 1'b0;

        foreach (vq[i]) begin
            req = vq[i].req;
            {p4, p3, p2, p1} = vq[i].prio;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vq[i].gnt, vq[i].id,
                  vq[i].busy, vq[i].to, vq[i].toid);
        end

        // reset between edges while client 3 holds the bus
        #2 reset = 1'b1;
        #1;
        check("mid_grant_reset", 4'b0000, 2'd0, 0, 0, 2'd0);
        @(posedge clk); #1;
        check("reset_held", 4'b0000, 2'd0, 0, 0, 2'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("regrant_after_reset", 4'b0100, 2'd2, 1, 0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
